// File: rtl/adc_scan_arbiter.sv
// Round-robin SPI scan arbiter sharing one MCP3004/3008-class ADC among requesters.
// Optional ADC_DIFF_EN adds req_diff to select differential (SGL=0) conversions.
module adc_scan_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SCLK_HALF = 675
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [3*NUM_REQ-1:0]       req_ch,
`ifdef ADC_DIFF_EN
  input  logic [NUM_REQ-1:0]         req_diff,
`endif
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [9:0]                 rsp_data,
  output logic                       busy,
  output logic                       AD_CLK,
  output logic                       CS,
  output logic                       DIN,
  input  logic                       DOUT
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(2*SCLK_HALF+1);
  localparam logic [IW:0]   NR    = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST  = IW'(NUM_REQ-1);
  localparam logic [CW-1:0] HLAST = CW'(SCLK_HALF-1);
  localparam logic [CW-1:0] FLAST = CW'(2*SCLK_HALF-1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, CSHIGH, RESP
  } st_t;

  st_t           state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          ph, ph_d;
  logic [4:0]    per, per_d;
  logic [IW-1:0] ptr, ptr_d;
  logic [IW-1:0] win, win_d;
  logic [2:0]    ch, ch_d;
  logic          sgl, sgl_d;
  logic [9:0]    sh, sh_d;
  logic          hit;
  logic [IW-1:0] pick;
  logic [IW:0]   idx;
  logic          cs_d, sclk_d, din_d, vld_d;

  always_comb begin
    hit  = 1'b0;
    pick = '0;
    idx  = '0;
    // Walk from the farthest offset down so the nearest set bit wins.
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (IW+1)'(i);
      if (idx >= NR) idx = idx - NR;
      if (req[idx[IW-1:0]]) begin
        hit  = 1'b1;
        pick = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ph_d    = ph;
    per_d   = per;
    ptr_d   = ptr;
    win_d   = win;
    ch_d    = ch;
    sgl_d   = sgl;
    sh_d    = sh;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_d = SETUP;
          cnt_d   = '0;
          win_d   = pick;
          ch_d    = req_ch[3*int'(pick) +: 3];
`ifdef ADC_DIFF_EN
          sgl_d   = ~req_diff[pick];
`else
          sgl_d   = 1'b1;
`endif
          ptr_d   = (pick == LAST) ? '0 : pick + 1'b1;
        end
      end
      SETUP: begin
        if (cnt == HLAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          ph_d    = 1'b0;
          per_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != HLAST) begin
          cnt_d = cnt + 1'b1;
        end else begin
          cnt_d = '0;
          if (!ph) begin
            // AD_CLK rises on this edge; ADC data is stable here.
            ph_d = 1'b1;
            if (per >= 5'd7) sh_d = {sh[8:0], DOUT};
          end else begin
            ph_d = 1'b0;
            if (per == 5'd16) state_d = CSHIGH;
            else              per_d   = per + 1'b1;
          end
        end
      end
      CSHIGH: begin
        if (cnt == FLAST) state_d = RESP;
        else              cnt_d   = cnt + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cs_d   = !(state_d == SETUP || state_d == SHIFT);
    sclk_d = (state_d == SHIFT) && ph_d;
    vld_d  = (state_d == RESP);
    din_d  = 1'b0;
    if (state_d == SETUP) begin
      din_d = 1'b1;
    end else if (state_d == SHIFT) begin
      unique case (per_d)
        5'd0:    din_d = 1'b1;
        5'd1:    din_d = sgl_d;
        5'd2:    din_d = ch_d[2];
        5'd3:    din_d = ch_d[1];
        5'd4:    din_d = ch_d[0];
        default: din_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ph        <= 1'b0;
      per       <= '0;
      ptr       <= '0;
      win       <= '0;
      ch        <= '0;
      sgl       <= 1'b1;
      sh        <= '0;
      CS        <= 1'b1;
      AD_CLK    <= 1'b0;
      DIN       <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      ph        <= ph_d;
      per       <= per_d;
      ptr       <= ptr_d;
      win       <= win_d;
      ch        <= ch_d;
      sgl       <= sgl_d;
      sh        <= sh_d;
      CS        <= cs_d;
      AD_CLK    <= sclk_d;
      DIN       <= din_d;
      busy      <= (state_d != IDLE);
      rsp_valid <= vld_d;
      if (vld_d) begin
        rsp_id   <= win;
        rsp_data <= sh_d;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_arbiter.sv
// Directed bench for adc_scan_arbiter with a small MCP3008 bus model on DOUT.
// Runs NUM_REQ=4, SCLK_HALF=2; honours ADC_DIFF_EN for the SGL-bit check.
module tb_adc_scan_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] req_ch = '0;
  logic [3:0]  req_diff = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [9:0]  rsp_data;
  logic        busy, AD_CLK, CS, DIN;
  logic        DOUT = 1'b0;

  int          total = 0;
  int          bad = 0;
  int          rises = 0;
  logic        din_bits [0:31];
  logic [9:0]  model_val = '0;
  int          run = 0;
  int          last_run = 0;
  int          vcount = 0;

  always #5 clk = ~clk;

  adc_scan_arbiter #(.NUM_REQ(4), .SCLK_HALF(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_ch(req_ch),
`ifdef ADC_DIFF_EN
    .req_diff(req_diff),
`endif
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .busy(busy),
    .AD_CLK(AD_CLK),
    .CS(CS),
    .DIN(DIN),
    .DOUT(DOUT)
  );

  always @(posedge AD_CLK or negedge CS) begin
    if (AD_CLK === 1'b1) begin
      if (rises < 32) din_bits[rises] = DIN;
      rises = rises + 1;
    end else begin
      rises = 0;
    end
  end

  // ADC shifts the next result bit out on each falling AD_CLK.
  always @(negedge AD_CLK) begin
    if (rises >= 7 && rises <= 16) DOUT = model_val[16-rises];
    else                           DOUT = 1'b0;
  end

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) vcount = vcount + 1;
    if (CS === 1'b1) begin
      run = run + 1;
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_frame(input logic [3:0] m, input logic [9:0] v,
                          input bit keep, output int n,
                          output logic [1:0] id, output logic [9:0] d);
    model_val = v;
    req = m;
    n = 0;
    while (1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rsp_valid === 1'b1 || n >= 400) break;
    end
    if (rsp_valid !== 1'b1) chk("timeout", 32'd0, 32'd1);
    id = rsp_id;
    d = rsp_data;
    if (!keep) req = '0;
    @(negedge clk);
    chk("pulse_width", 32'(rsp_valid), 32'd0);
  endtask

  int         n;
  logic [1:0] id;
  logic [9:0] d;
  logic [4:0] din_exp;
  logic [1:0] ids_exp [0:4];
  logic [9:0] vals [0:4];
  int         vsnap;
  logic       sgl_exp;

  initial begin
    rst_n = 1'b0;
    req = 4'hF;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_pins", 32'({CS, AD_CLK, DIN, busy, rsp_valid}), 32'b10000);
      chk("reset_rsp", 32'({rsp_id, rsp_data}), 32'd0);
    end
    req = '0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    req_ch = 12'd5 << 6;
    do_frame(4'b0100, 10'h2A5, 1'b0, n, id, d);
    chk("t2_latency", 32'(n), 32'd75);
    chk("t2_id", 32'(id), 32'd2);
    chk("t2_data", 32'(d), 32'h2A5);
    chk("t2_rises", 32'(rises), 32'd17);
    chk("t2_busy_after", 32'(busy), 32'd0);
    chk("t2_rsp_hold", 32'(rsp_data), 32'h2A5);
    din_exp = 5'b11101;
    for (int i = 0; i < 5; i++) chk("t2_din", 32'(din_bits[i]), 32'(din_exp[4-i]));

    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_ch = {3'd3, 3'd2, 3'd1, 3'd0};
    ids_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    vals = '{10'h001, 10'h155, 10'h2AA, 10'h3FE, 10'h123};
    for (int k = 0; k < 5; k++) begin
      do_frame(4'hF, vals[k], k < 4, n, id, d);
      chk("t3_id", 32'(id), 32'(ids_exp[k]));
      chk("t3_data", 32'(d), 32'(vals[k]));
      if (k > 0) chk("t3_cs_gap", 32'(last_run), 32'd6);
    end

    req_ch = {3'd0, 3'd0, 3'd7, 3'd0};
    do_frame(4'b0001, 10'h000, 1'b0, n, id, d);
    chk("t4_id0", 32'(id), 32'd0);
    chk("t4_data0", 32'(d), 32'h000);
    chk("t4_ch0", 32'({din_bits[2], din_bits[3], din_bits[4]}), 32'd0);
    do_frame(4'b0010, 10'h3FF, 1'b0, n, id, d);
    chk("t4_id1", 32'(id), 32'd1);
    chk("t4_data1", 32'(d), 32'h3FF);
    chk("t4_ch7", 32'({din_bits[2], din_bits[3], din_bits[4]}), 32'd7);

    req_ch = {3'd0, 3'd0, 3'd3, 3'd0};
    req_diff = 4'b0010;
`ifdef ADC_DIFF_EN
    sgl_exp = 1'b0;
`else
    sgl_exp = 1'b1;
`endif
    do_frame(4'b0010, 10'h0F0, 1'b0, n, id, d);
    chk("t6_sgl", 32'(din_bits[1]), 32'(sgl_exp));
    chk("t6_ch3", 32'({din_bits[2], din_bits[3], din_bits[4]}), 32'd3);
    chk("t6_data", 32'(d), 32'h0F0);

    model_val = 10'h3C3;
    req = 4'b0010;
    n = 0;
    while (!(rises == 8 && AD_CLK === 1'b0 && CS === 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_p8", 32'(n < 300), 32'd1);
    vsnap = vcount;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_cs", 32'(CS), 32'd1);
    chk("t5_pins", 32'({AD_CLK, DIN, busy}), 32'd0);
    rst_n = 1'b1;
    req = '0;
    repeat (100) @(negedge clk);
    chk("t5_no_rsp", 32'(vcount), 32'(vsnap));
    req_ch = {3'd0, 3'd4, 3'd6, 3'd0};
    do_frame(4'b0110, 10'h155, 1'b0, n, id, d);
    chk("t5_latency", 32'(n), 32'd75);
    chk("t5_ptr_id", 32'(id), 32'd1);
    chk("t5_data", 32'(d), 32'h155);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
